seq_cmp: RTL and testbench

SEQ_CMP -- requirements
Module: seq_cmp

---
 rtl/seq_cmp_pkg.sv | 13 +
 rtl/seq_cmp_chunk.sv | 12 +
 rtl/seq_cmp.sv | 87 ++++++++
 tb/tb_seq_cmp.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/seq_cmp_pkg.sv
// seq_cmp_pkg: op encodings, FSM state type and flag-to-result mapping for seq_cmp
package seq_cmp_pkg;
  localparam logic [2:0] OP_EQ = 3'd0, OP_NE = 3'd1, OP_LT = 3'd2, OP_LE = 3'd3, OP_GT = 3'd4, OP_GE = 3'd5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic cmp_result(input logic [2:0] op, input logic lt, input logic z);
    return op == OP_EQ ? z :
           op == OP_NE ? !z :
           op == OP_LT ? lt :
           op == OP_LE ? (lt | z) :
           op == OP_GT ? !(lt | z) :
           op == OP_GE ? !lt : 1'b0;
  endfunction
endpackage

// File: rtl/seq_cmp_chunk.sv
// seq_cmp_chunk: W-bit slice computing a + ~b + cin -> {cout, sum}
module seq_cmp_chunk #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, ~b} + (W + 1)'(cin);
endmodule

// File: rtl/seq_cmp.sv
// seq_cmp: chunk-serial signed/unsigned comparator; CLK/RESET, request in_valid/in_ready with I0, I1, op, is_signed, result out_valid/out_ready with O; SEQ_CMP_DIFF_EN adds the diff output
module seq_cmp
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [2:0]       op,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             O
`ifdef SEQ_CMP_DIFF_EN
  ,
  output logic [WIDTH-1:0] diff
`endif
);
  localparam int K  = WIDTH / CHUNK;
  localparam int CW = K > 1 ? $clog2(K) : 1;
  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic [2:0]       op_r;
  logic             sgn_r, a_msb, b_msb, carry, zero;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] s;
  logic             cout, last, z, n, v, lt;
  seq_cmp_chunk #(.W(CHUNK)) u_chunk (
    .a   (a_r[CHUNK-1:0]),
    .b   (b_r[CHUNK-1:0]),
    .cin (carry),
    .sum (s),
    .cout(cout)
  );
  assign last = cnt == CW'(K - 1);
  assign z    = zero & ~|s;
  assign n    = s[CHUNK-1];
  assign v    = (a_msb ^ b_msb) & (n ^ a_msb);
  assign lt   = sgn_r ? n ^ v : ~cout;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
                               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      O     <= 1'b0;
      zero  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        a_r   <= I0;
        b_r   <= I1;
        op_r  <= op;
        sgn_r <= is_signed;
        a_msb <= I0[WIDTH-1];
        b_msb <= I1[WIDTH-1];
        cnt   <= '0;
        carry <= 1'b1;
        zero  <= 1'b1;
      end else if (state == RUN) begin
        a_r   <= a_r >> CHUNK;
        b_r   <= b_r >> CHUNK;
        cnt   <= cnt + CW'(1);
        carry <= cout;
        zero  <= z;
        if (last) O <= cmp_result(op_r, lt, z);
      end
    end
  end
`ifdef SEQ_CMP_DIFF_EN
  always_ff @(posedge CLK) begin
    if (RESET) diff <= '0;
    else if (state == RUN) diff <= WIDTH'({s, diff} >> CHUNK);
  end
`endif
endmodule

// File: tb/tb_seq_cmp.sv
// tb_seq_cmp: randomized scoreboard bench for seq_cmp against an integer-arithmetic model
module tb_seq_cmp;
  localparam int W = 8, CH = 2, K = W / CH;
  logic CLK = 0, RESET = 1, in_valid = 0, is_signed = 0, out_ready = 1;
  logic [W-1:0] I0 = 0, I1 = 0;
  logic [2:0] op = 0;
  logic in_ready, out_valid, O;
`ifdef SEQ_CMP_DIFF_EN
  logic [W-1:0] diff;
`endif
  seq_cmp #(.WIDTH(W), .CHUNK(CH)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .I0(I0), .I1(I1), .op(op), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .O(O)
`ifdef SEQ_CMP_DIFF_EN
    , .diff(diff)
`endif
  );
  always #5 CLK = ~CLK;
  typedef struct {logic o; logic [W-1:0] d;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, accept_cyc = 0;
  bit hold_rdy = 0, rand_rdy = 0, seen = 0, chk_idle = 0;
  logic held;
  always @(posedge CLK) cyc++;
  always @(posedge CLK) begin
    #1 out_ready = hold_rdy ? 1'b0 : rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o, input logic sg);
    int x, y;
    exp_t e;
    x = int'(a);
    y = int'(b);
    if (sg && a[W-1]) x -= (1 << W);
    if (sg && b[W-1]) y -= (1 << W);
    case (o)
      3'd0: e.o = x == y;
      3'd1: e.o = x != y;
      3'd2: e.o = x < y;
      3'd3: e.o = x <= y;
      3'd4: e.o = x > y;
      3'd5: e.o = x >= y;
      default: e.o = 1'b0;
    endcase
    e.d = W'(a - b);
    return e;
  endfunction
  always @(negedge CLK) begin
    exp_t e;
    if (chk_idle) begin
      check("idle_after_done", {30'd0, out_valid, in_ready}, 32'b01);
      chk_idle = 0;
    end
    if (RESET) seen = 0;
    else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        held = O;
        check("latency", cyc - accept_cyc, K + 1);
      end else check("O_hold", O, held);
      check("in_ready_in_done", in_ready, 0);
      if (out_ready) begin
        if (q.size() == 0) check("unexpected_output", 1, 0);
        else begin
          e = q.pop_front();
          check("result", O, e.o);
`ifdef SEQ_CMP_DIFF_EN
          check("diff", diff, e.d);
`endif
        end
        seen = 0;
        chk_idle = 1;
      end
    end
  end
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o, input logic sg);
    int t = 0;
    @(negedge CLK);
    I0 = a; I1 = b; op = o; is_signed = sg; in_valid = 1;
    while (!in_ready && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (!in_ready) check("issue_timeout", 0, 1);
    accept_cyc = cyc;
    q.push_back(model(a, b, o, sg));
    @(negedge CLK);
    in_valid = 0;
    I0 = W'($urandom); I1 = W'($urandom); op = 3'($urandom); is_signed = 1'($urandom);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 80 && q.size() != 0; i++) @(negedge CLK);
    if (q.size() != 0) begin
      check("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask
  task automatic req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o, input logic sg);
    issue(a, b, o, sg);
    wait_done();
  endtask
  function automatic logic [W-1:0] pick();
    int r = $urandom_range(0, 5);
    return r == 0 ? W'(0) : r == 1 ? W'(8'h80) : r == 2 ? W'(8'h7F) : r == 3 ? W'(8'hFF) : W'($urandom);
  endfunction
  initial begin
    repeat (2) @(negedge CLK);
    RESET = 0;
    @(negedge CLK);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_O", O, 0);
`ifdef SEQ_CMP_DIFF_EN
    check("reset_diff", diff, 0);
`endif
    req(8'h80, 8'h7F, 3'd5, 1);
    req(8'h80, 8'h7F, 3'd5, 0);
    req(8'h5A, 8'h5A, 3'd0, 0);
    req(8'h5A, 8'h5A, 3'd1, 0);
    req(8'h5A, 8'h5A, 3'd3, 1);
    req(8'h5A, 8'h5A, 3'd4, 1);
    req(8'h7F, 8'h80, 3'd2, 1);
    req(8'h7F, 8'h80, 3'd4, 1);
    req(8'h7F, 8'h80, 3'd7, 1);
    req(8'h03, 8'h05, 3'd2, 1);
    hold_rdy = 1;
    issue(8'h12, 8'h34, 3'd2, 0);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; I0 = 8'h00; I1 = 8'h00; op = 3'd0;
      check("stall_out_valid", out_valid, 1);
      @(negedge CLK);
    end
    in_valid = 0;
    hold_rdy = 0;
    wait_done();
    repeat (8) @(negedge CLK);
    issue(8'h40, 8'h20, 3'd4, 0);
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    void'(q.pop_back());
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    repeat (10) @(negedge CLK);
    req(8'h40, 8'h20, 3'd4, 0);
    rand_rdy = 1;
    for (int i = 0; i < 200; i++) req(pick(), pick(), 3'($urandom_range(0, 7)), 1'($urandom));
    rand_rdy = 0;
    repeat (5) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
